// File: rtl/sblk_row_dist.sv
// rtl/sblk_row_dist.sv - activation/instruction fan-out to a row of superblocks
module sblk_row_dist #(
  parameter int N_ROW      = 4,
  parameter int WID_ACT    = 16,
  parameter int N_ACT_WORD = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int WID_INST   = 14,
  parameter int INST_HOLD  = 3
) (
  input  logic                                clk_l,
  input  logic                                rst_n,
  input  logic [N_ACT_WORD*WID_ACT-1:0]       s_act_data,
  input  logic [N_ROW-1:0]                    s_act_mask,
  input  logic                                s_act_vld,
  output logic                                s_act_rdy,
  output logic [N_ROW*N_ACT_WORD*WID_ACT-1:0] m_act_data,
  output logic [N_ROW-1:0]                    m_act_vld,
  input  logic [N_ROW-1:0]                    m_act_req,
  input  logic [WID_INST-1:0]                 s_inst_data,
  input  logic [N_ROW-1:0]                    s_inst_mask,
  input  logic                                s_inst_vld,
  output logic                                s_inst_rdy,
  output logic [N_ROW*WID_INST-1:0]           m_inst_data,
  output logic [N_ROW-1:0]                    m_inst_en,
  input  logic [N_ROW-1:0]                    status_sblk,
  output logic [N_ROW-1:0]                    act_fifo_empty,
  output logic                                all_idle
);
  localparam int WW = N_ACT_WORD * WID_ACT;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(INST_HOLD + 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [HW-1:0] HOLD_LD  = HW'(INST_HOLD);

  logic [WW-1:0]   mem  [N_ROW][FIFO_DEPTH];
  logic [AW:0]     cnt  [N_ROW];
  logic [AW-1:0]   wptr [N_ROW];
  logic [AW-1:0]   rptr [N_ROW];
  logic [HW-1:0]   hold [N_ROW];

  logic [N_ROW-1:0] act_room, act_push, act_pop;
  logic [N_ROW-1:0] inst_free, inst_ok, hold_zero;
  logic             act_acc, inst_acc;

  always_comb begin
    act_room   = '0;
    act_pop    = '0;
    hold_zero  = '0;
    inst_free  = '0;
    m_act_vld  = '0;
    m_act_data = '0;
    for (int r = 0; r < N_ROW; r++) begin
      act_room[r]  = ~s_act_mask[r] | (cnt[r] != CNT_FULL);
      m_act_vld[r] = (cnt[r] != '0);
      act_pop[r]   = m_act_vld[r] & m_act_req[r];
      m_act_data[r*WW +: WW] = mem[r][rptr[r]];
      hold_zero[r] = (hold[r] == '0);
      inst_free[r] = status_sblk[r] & hold_zero[r] & ~m_inst_en[r];
    end
  end

  // Push decision uses registered counts only, so a same-cycle pop never frees room.
  assign s_act_rdy      = rst_n & (&act_room);
  assign act_acc        = s_act_vld & s_act_rdy;
  assign act_push       = {N_ROW{act_acc}} & s_act_mask;
  assign act_fifo_empty = ~m_act_vld;

  assign inst_ok    = ~s_inst_mask | inst_free;
  assign s_inst_rdy = rst_n & (&inst_ok);
  assign inst_acc   = s_inst_vld & s_inst_rdy;

  assign all_idle = rst_n & (&act_fifo_empty) & (&status_sblk) & (&hold_zero) & ~(|m_inst_en);

  always_ff @(posedge clk_l) begin
    for (int r = 0; r < N_ROW; r++) begin
      if (act_push[r]) mem[r][wptr[r]] <= s_act_data;
    end
  end

  always_ff @(posedge clk_l) begin
    if (!rst_n) begin
      for (int r = 0; r < N_ROW; r++) begin
        cnt[r]  <= '0;
        wptr[r] <= '0;
        rptr[r] <= '0;
      end
    end else begin
      for (int r = 0; r < N_ROW; r++) begin
        if (act_push[r]) wptr[r] <= wptr[r] + 1'b1;
        if (act_pop[r])  rptr[r] <= rptr[r] + 1'b1;
        if (act_push[r] && !act_pop[r])      cnt[r] <= cnt[r] + 1'b1;
        else if (act_pop[r] && !act_push[r]) cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  // Hold counts down from load, so the strobe cycle is the first of INST_HOLD blocked cycles.
  always_ff @(posedge clk_l) begin
    if (!rst_n) begin
      m_inst_en   <= '0;
      m_inst_data <= '0;
      for (int r = 0; r < N_ROW; r++) hold[r] <= '0;
    end else begin
      for (int r = 0; r < N_ROW; r++) begin
        if (inst_acc && s_inst_mask[r]) begin
          m_inst_data[r*WID_INST +: WID_INST] <= s_inst_data;
          m_inst_en[r] <= 1'b1;
          hold[r]      <= HOLD_LD;
        end else begin
          m_inst_en[r] <= 1'b0;
          if (!hold_zero[r]) hold[r] <= hold[r] - 1'b1;
        end
      end
    end
  end
endmodule
